// File: rtl/reg_strobe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : reg_strobe_sequencer
// Brief   : Two-phase (address, then data) register strobe sequencer with a
//           synchronised strobe edge detector, auto-increment and sticky error.
// Revision: 1.0
// ============================================================================
module reg_strobe_sequencer #(
    parameter int ADDR_W      = 4,
    parameter int N_REGS      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              strob_in,
    input  logic              choose_data_reg,
    input  logic              auto_inc,
    output logic [N_REGS-1:0] strob_out_to_reg,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              addr_valid,
    output logic              err
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ARMED = 1'b1
    } state_t;

    localparam logic [ADDR_W:0]   C_NREGS = (ADDR_W + 1)'(N_REGS);
    localparam logic [ADDR_W-1:0] C_LAST  = ADDR_W'(N_REGS - 1);
    localparam logic [ADDR_W-1:0] C_ONE   = ADDR_W'(1);

    logic              w_s;
    logic              w_rise_now;
    logic              w_addr_ok;
    logic              w_fire;

    state_t            state_q,    state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic              err_q,      err_d;
    logic [N_REGS-1:0] strob_q,    strob_d;
    logic              s_d_q,      s_d_d;
    logic              rise_q,     rise_d;
    logic [ADDR_W-1:0] addr_cap_q, addr_cap_d;
    logic              choose_cap_q, choose_cap_d;
    logic              inc_cap_q,  inc_cap_d;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign w_s = strob_in;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sync_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync_q <= '0;
                end else begin
                    sync_q[0] <= strob_in;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sync_q[i] <= sync_q[i-1];
                    end
                end
            end
            assign w_s = sync_q[SYNC_STAGES-1];
        end
    endgenerate

    // Rise is registered so the bus fields are captured alongside it, one clk
    // before the FSM acts on them.
    assign w_rise_now = w_s & ~s_d_q;
    assign w_addr_ok  = ({1'b0, addr_cap_q} < C_NREGS);

    always_comb begin
        s_d_d        = w_s;
        rise_d       = w_rise_now;
        addr_cap_d   = addr_cap_q;
        choose_cap_d = choose_cap_q;
        inc_cap_d    = inc_cap_q;
        if (w_rise_now) begin
            addr_cap_d   = data_in;
            choose_cap_d = choose_data_reg;
            inc_cap_d    = auto_inc;
        end

        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        err_d      = err_q;
        w_fire     = 1'b0;
        if (rise_q) begin
            if (!choose_cap_q) begin
                if (w_addr_ok) begin
                    state_d    = ST_ARMED;
                    cur_addr_d = addr_cap_q;
                    err_d      = 1'b0;
                end else begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end
            end else if (state_q == ST_ARMED) begin
                w_fire = 1'b1;
                if (inc_cap_q) begin
                    // Wrap at the last implemented register, not at 2**ADDR_W.
                    cur_addr_d = (cur_addr_q == C_LAST) ? '0 : cur_addr_q + C_ONE;
                end
            end else begin
                err_d = 1'b1;
            end
        end
    end

    generate
        for (genvar g = 0; g < N_REGS; g++) begin : g_dec
            assign strob_d[g] = w_fire & (cur_addr_q == ADDR_W'(g));
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cur_addr_q   <= '0;
            err_q        <= 1'b0;
            strob_q      <= '0;
            s_d_q        <= 1'b0;
            rise_q       <= 1'b0;
            addr_cap_q   <= '0;
            choose_cap_q <= 1'b0;
            inc_cap_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_addr_q   <= cur_addr_d;
            err_q        <= err_d;
            strob_q      <= strob_d;
            s_d_q        <= s_d_d;
            rise_q       <= rise_d;
            addr_cap_q   <= addr_cap_d;
            choose_cap_q <= choose_cap_d;
            inc_cap_q    <= inc_cap_d;
        end
    end

    assign strob_out_to_reg = strob_q;
    assign cur_addr         = cur_addr_q;
    assign addr_valid       = (state_q == ST_ARMED);
    assign err              = err_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_strobe_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_reg_strobe_sequencer
// Brief   : Directed self-checking bench; a 16-register and a 12-register
//           instance share the bus stimulus.
// Revision: 1.0
// ============================================================================
module tb_reg_strobe_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  data_in = '0;
    logic        strob_in = 1'b0;
    logic        choose_data_reg = 1'b0;
    logic        auto_inc = 1'b0;

    logic [15:0] strob16;
    logic [3:0]  addr16;
    logic        valid16, err16;
    logic [11:0] strob12;
    logic [3:0]  addr12;
    logic        valid12, err12;

    int checks   = 0;
    int failures = 0;

    reg_strobe_sequencer #(.ADDR_W(4), .N_REGS(16), .SYNC_STAGES(2)) u_dut16 (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .strob_in         (strob_in),
        .choose_data_reg  (choose_data_reg),
        .auto_inc         (auto_inc),
        .strob_out_to_reg (strob16),
        .cur_addr         (addr16),
        .addr_valid       (valid16),
        .err              (err16)
    );

    reg_strobe_sequencer #(.ADDR_W(4), .N_REGS(12), .SYNC_STAGES(2)) u_dut12 (
        .clk              (clk),
        .rst              (rst),
        .data_in          (data_in),
        .strob_in         (strob_in),
        .choose_data_reg  (choose_data_reg),
        .auto_inc         (auto_inc),
        .strob_out_to_reg (strob12),
        .cur_addr         (addr12),
        .addr_valid       (valid12),
        .err              (err12)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One bus access: strob_in high for 'hold' clks, then a quiet tail.
    // Strobe activity of both instances is recorded over the whole window.
    task automatic phase(input logic [3:0] addr, input logic choose, input logic inc,
                         input int hold,
                         output int hits16, output logic [15:0] v16, output int at16,
                         output int hits12, output logic [11:0] v12);
        hits16 = 0; v16 = '0; at16 = 0; hits12 = 0; v12 = '0;
        @(negedge clk);
        data_in = addr; choose_data_reg = choose; auto_inc = inc; strob_in = 1'b1;
        for (int k = 1; k <= hold + 6; k++) begin
            @(negedge clk);
            if (k == hold) strob_in = 1'b0;
            if (strob16 != '0) begin
                hits16++; v16 = strob16;
                if (at16 == 0) at16 = k;
            end
            if (strob12 != '0) begin
                hits12++; v12 = strob12;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int          h16, a16, h12;
    logic [15:0] s16;
    logic [11:0] s12;

    initial begin
        // Reset held while strob_in toggles
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            strob_in = ~strob_in;
            data_in  = 4'd7;
        end
        @(negedge clk);
        strob_in = 1'b0;
        chk("rst_strobe", 32'(strob16), 32'h0);
        chk("rst_addr",   32'(addr16),  32'h0);
        chk("rst_valid",  32'(valid16), 32'h0);
        chk("rst_err",    32'(err16),   32'h0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("post_rst_valid", 32'(valid16), 32'h0);

        // Address 5 then data phase, no auto-increment
        phase(4'd5, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t2_addr_no_strobe", 32'(h16), 32'd0);
        chk("t2_valid", 32'(valid16), 32'd1);
        phase(4'd0, 1'b1, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t2_hits",    32'(h16), 32'd1);
        chk("t2_strobe",  32'(s16), 32'h0020);
        chk("t2_latency", 32'(a16), 32'd4);
        chk("t2_addr",    32'(addr16), 32'd5);

        // Auto-increment across the 15 -> 0 wrap
        phase(4'd14, 1'b0, 1'b1, 1, h16, s16, a16, h12, s12);
        phase(4'd0, 1'b1, 1'b1, 1, h16, s16, a16, h12, s12);
        chk("t3_strobe0", 32'(s16), 32'h4000);
        phase(4'd0, 1'b1, 1'b1, 1, h16, s16, a16, h12, s12);
        chk("t3_strobe1", 32'(s16), 32'h8000);
        phase(4'd0, 1'b1, 1'b1, 1, h16, s16, a16, h12, s12);
        chk("t3_strobe2", 32'(s16), 32'h0001);
        chk("t3_hits",    32'(h16), 32'd1);
        chk("t3_addr",    32'(addr16), 32'd1);

        // Data phase from IDLE, then a valid address clears the error
        do_reset();
        phase(4'd0, 1'b1, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t4_no_strobe", 32'(h16), 32'd0);
        chk("t4_err",       32'(err16), 32'd1);
        chk("t4_idle",      32'(valid16), 32'd0);
        phase(4'd3, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t4_err_clr", 32'(err16), 32'd0);
        chk("t4_valid",   32'(valid16), 32'd1);
        chk("t4_addr",    32'(addr16), 32'd3);

        // 12-register instance: out-of-range codes and a long strobe
        do_reset();
        phase(4'd13, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t5_err13",   32'(err12), 32'd1);
        chk("t5_valid13", 32'(valid12), 32'd0);
        chk("t5_addr13",  32'(addr12), 32'd0);
        phase(4'd0, 1'b1, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t5_no_strobe", 32'(h12), 32'd0);
        phase(4'd11, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t5_valid11", 32'(valid12), 32'd1);
        chk("t5_err11",   32'(err12), 32'd0);
        phase(4'd0, 1'b1, 1'b0, 10, h16, s16, a16, h12, s12);
        chk("t5_long_hits",   32'(h12), 32'd1);
        chk("t5_long_strobe", 32'(s12), 32'h800);
        phase(4'd12, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        chk("t5_err12",   32'(err12), 32'd1);
        chk("t5_valid12", 32'(valid12), 32'd0);
        chk("t5_keep11",  32'(addr12), 32'd11);

        // Reset while the strobe is high
        do_reset();
        phase(4'd5, 1'b0, 1'b0, 1, h16, s16, a16, h12, s12);
        @(negedge clk);
        data_in = 4'd0; choose_data_reg = 1'b1; strob_in = 1'b1;
        @(negedge clk);
        strob_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("t6_pre_strobe", 32'(strob16), 32'h0020);
        rst = 1'b1;
        #1;
        chk("t6_async_strobe", 32'(strob16), 32'h0);
        chk("t6_async_addr",   32'(addr16),  32'h0);
        chk("t6_async_valid",  32'(valid16), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        h16 = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (strob16 != '0) h16++;
        end
        chk("t6_no_strobe_after", 32'(h16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
